// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car path: FSM states, run modes,
// one-hot floor codes, default timing and the floor-shift helper.
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MOVE  = 2'd1,
      CHECK = 2'd2,
      DOOR  = 2'd3
   } car_state_t;

   localparam logic [1:0] MODE_STOP = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;

   localparam logic [3:0] FLOOR1 = 4'b0001;
   localparam logic [3:0] FLOOR2 = 4'b0010;
   localparam logic [3:0] FLOOR3 = 4'b0100;
   localparam logic [3:0] FLOOR4 = 4'b1000;

   localparam int TICKS_PER_FLOOR_DEF = 64;
   localparam int DOOR_OPEN_TICKS_DEF = 96;
   localparam int HOLD_TICKS_DEF      = 32;

   // One-floor move in the given direction; the end floors hold their position.
   function automatic logic [3:0] shift_floor(input logic [3:0] pos, input logic [1:0] dir);
      logic [3:0] res;
      res = pos;
      if (dir == MODE_UP && pos != FLOOR4)
         res = pos << 1;
      else if (dir == MODE_DOWN && pos != FLOOR1)
         res = pos >> 1;
      return res;
   endfunction

endpackage

// File: rtl/car_tick_timer.sv
// Tick counter shared by travel and door timing: clear, count up, saturating
// pull-back for door hold, and a done flag at a programmable terminal count.
module car_tick_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_sub,
   input  logic [CNT_W-1:0] i_sub_val,
   input  logic [CNT_W-1:0] i_term,
   output logic             o_done
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_inc;
   logic [CNT_W-1:0] w_count_nxt;

   assign w_count_inc = r_count + CNT_W'(1);

   // NOTE: default assignment first so every path drives w_count_nxt and no latch is inferred.
   always_comb begin
      w_count_nxt = r_count;
      if (i_clr)
         w_count_nxt = '0;
      else if (i_en && i_sub)
         w_count_nxt = (w_count_inc > i_sub_val) ? (w_count_inc - i_sub_val) : '0;
      else if (i_en)
         w_count_nxt = w_count_inc;
   end

   // NOTE: clocked state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else
         r_count <= w_count_nxt;
   end

   assign o_done = (r_count == i_term);

endmodule

// File: rtl/car_motion_ctrl.sv
// Elevator car motion FSM: travel one floor per TICKS_PER_FLOOR, stop and open
// the door at requested floors. Door-hold extension enabled by CAR_DOOR_HOLD_EN.
module car_motion_ctrl
   import elevator_pkg::*;
#(
   parameter int TICKS_PER_FLOOR = TICKS_PER_FLOOR_DEF,
   parameter int DOOR_OPEN_TICKS = DOOR_OPEN_TICKS_DEF,
   parameter int HOLD_TICKS      = HOLD_TICKS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ud_mode,
   input  logic [3:0] stop_req,
   input  logic       door_hold,
   output logic [3:0] position,
   output logic       door_open,
   output logic       moving,
   output logic [1:0] dir,
   output logic [3:0] served
);

   localparam int MAX_TICKS = (TICKS_PER_FLOOR > DOOR_OPEN_TICKS) ? TICKS_PER_FLOOR : DOOR_OPEN_TICKS;
   // Spare bit keeps count+1 from wrapping when the pull-back is applied.
   localparam int CNT_W = $clog2(MAX_TICKS) + 1;
   localparam logic [CNT_W-1:0] MOVE_TERM = CNT_W'(TICKS_PER_FLOOR - 1);
   localparam logic [CNT_W-1:0] DOOR_TERM = CNT_W'(DOOR_OPEN_TICKS - 1);
   localparam logic [CNT_W-1:0] HOLD_VAL  = CNT_W'(HOLD_TICKS);

   car_state_t       r_state;
   car_state_t       w_state_nxt;
   logic [3:0]       r_position;
   logic [3:0]       w_position_nxt;
   logic [1:0]       r_dir;
   logic [1:0]       w_dir_nxt;
   logic [3:0]       r_served;
   logic [3:0]       w_served_nxt;
   logic             r_door_open;
   logic             r_moving;

   logic [1:0]       w_mode;
   logic             w_hit;
   logic             w_can_continue;
   logic             w_tmr_clr;
   logic             w_tmr_en;
   logic             w_tmr_done;
   logic [CNT_W-1:0] w_tmr_term;
   logic             w_hold_edge;

   assign w_mode         = (ud_mode == 2'b11) ? MODE_STOP : ud_mode;
   assign w_hit          = |(stop_req & r_position);
   assign w_can_continue = (r_dir == MODE_UP   && r_position != FLOOR4) ||
                           (r_dir == MODE_DOWN && r_position != FLOOR1);

`ifdef CAR_DOOR_HOLD_EN
   logic       r_hold_d;
   logic [2:0] r_hold_cnt;

   // Only the first four presses of a door cycle pull the counter back.
   assign w_hold_edge = door_hold && !r_hold_d && (r_state == DOOR) && (r_hold_cnt < 3'd4);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_d   <= 1'b0;
         r_hold_cnt <= 3'd0;
      end else begin
         r_hold_d <= door_hold;
         if (r_state != DOOR)
            r_hold_cnt <= 3'd0;
         else if (w_hold_edge)
            r_hold_cnt <= r_hold_cnt + 3'd1;
      end
   end
`else
   logic w_unused_hold;

   assign w_hold_edge   = 1'b0;
   assign w_unused_hold = door_hold;
`endif

   car_tick_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_tmr_clr),
      .i_en      (w_tmr_en),
      .i_sub     (w_hold_edge),
      .i_sub_val (HOLD_VAL),
      .i_term    (w_tmr_term),
      .o_done    (w_tmr_done)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_position_nxt = r_position;
      w_dir_nxt      = r_dir;
      w_served_nxt   = 4'b0000;
      w_tmr_clr      = 1'b0;
      w_tmr_en       = 1'b0;
      w_tmr_term     = MOVE_TERM;

      case (r_state)
         IDLE: begin
            w_dir_nxt = MODE_STOP;
            if (w_hit) begin
               w_state_nxt  = DOOR;
               w_served_nxt = r_position;
               w_tmr_clr    = 1'b1;
            end else if (w_mode == MODE_UP && r_position != FLOOR4) begin
               w_state_nxt = MOVE;
               w_dir_nxt   = MODE_UP;
               w_tmr_clr   = 1'b1;
            end else if (w_mode == MODE_DOWN && r_position != FLOOR1) begin
               w_state_nxt = MOVE;
               w_dir_nxt   = MODE_DOWN;
               w_tmr_clr   = 1'b1;
            end
         end

         MOVE: begin
            w_tmr_en = 1'b1;
            if (w_tmr_done) begin
               w_position_nxt = shift_floor(r_position, r_dir);
               w_tmr_clr      = 1'b1;
               w_state_nxt    = CHECK;
            end
         end

         // Single cycle so the request stage sees the new floor before we commit.
         CHECK: begin
            w_tmr_clr = 1'b1;
            if (w_hit) begin
               w_state_nxt  = DOOR;
               w_served_nxt = r_position;
            end else if (w_mode == r_dir && w_can_continue) begin
               w_state_nxt = MOVE;
            end else begin
               w_state_nxt = IDLE;
               w_dir_nxt   = MODE_STOP;
            end
         end

         DOOR: begin
            w_tmr_en   = 1'b1;
            w_tmr_term = DOOR_TERM;
            if (w_tmr_done) begin
               w_state_nxt = IDLE;
               w_dir_nxt   = MODE_STOP;
               w_tmr_clr   = 1'b1;
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_dir_nxt   = MODE_STOP;
            w_tmr_clr   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_position  <= FLOOR1;
         r_dir       <= MODE_STOP;
         r_served    <= 4'b0000;
         r_door_open <= 1'b0;
         r_moving    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_position  <= w_position_nxt;
         r_dir       <= w_dir_nxt;
         r_served    <= w_served_nxt;
         r_door_open <= (w_state_nxt == DOOR);
         r_moving    <= (w_state_nxt == MOVE);
      end
   end

   assign position  = r_position;
   assign door_open = r_door_open;
   assign moving    = r_moving;
   assign dir       = r_dir;
   assign served    = r_served;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Self-checking bench for car_motion_ctrl: decision table, hand-written trip,
// door, saturation and reset sequences, then random stimulus against a model.
module tb_car_motion_ctrl;

   localparam int TPF = 64;
   localparam int DOT = 96;
   localparam int HT  = 32;
`ifdef CAR_DOOR_HOLD_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   localparam int PH_IDLE  = 0;
   localparam int PH_MOVE  = 1;
   localparam int PH_CHECK = 2;
   localparam int PH_DOOR  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] ud_mode = 2'b00;
   logic [3:0] stop_req = 4'b0000;
   logic       door_hold = 1'b0;
   logic [3:0] position;
   logic       door_open;
   logic       moving;
   logic [1:0] dir;
   logic [3:0] served;

   int n_total = 0;
   int n_bad   = 0;

   // behavioural model: floor index, phase, cycles left in the phase
   int m_floor, m_phase, m_left, m_dir, m_presses;
   bit m_served, m_hold_d;

   typedef struct {
      logic [1:0] mode;
      logic [3:0] req;
      logic [3:0] e_pos;
      logic       e_door;
      logic       e_mov;
      logic [1:0] e_dir;
      logic [3:0] e_served;
   } vec_t;

   vec_t vecs[8];

   car_motion_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .ud_mode   (ud_mode),
      .stop_req  (stop_req),
      .door_hold (door_hold),
      .position  (position),
      .door_open (door_open),
      .moving    (moving),
      .dir       (dir),
      .served    (served)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   function automatic logic [11:0] pack_out(input logic [3:0] p, input logic d, input logic m,
                                            input logic [1:0] r, input logic [3:0] s);
      return {p, d, m, r, s};
   endfunction

   function automatic logic [11:0] dut_out();
      return pack_out(position, door_open, moving, dir, served);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_floor   = 0;
      m_phase   = PH_IDLE;
      m_left    = 0;
      m_dir     = 0;
      m_presses = 0;
      m_served  = 1'b0;
      m_hold_d  = 1'b0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      ud_mode   = 2'b00;
      stop_req  = 4'b0000;
      door_hold = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   function automatic bit in_range(input int f);
      return (f >= 0) && (f <= 3);
   endfunction

   task automatic model_step(input logic [1:0] mode, input logic [3:0] req, input logic hold);
      int md;
      md = (mode == 2'b01) ? 1 : ((mode == 2'b10) ? -1 : 0);
      m_served = 1'b0;
      case (m_phase)
         PH_IDLE: begin
            m_dir = 0;
            if (req[m_floor]) begin
               m_phase = PH_DOOR; m_left = DOT; m_served = 1'b1; m_presses = 0;
            end else if (md != 0 && in_range(m_floor + md)) begin
               m_phase = PH_MOVE; m_dir = md; m_left = TPF;
            end
         end
         PH_MOVE: begin
            m_left--;
            if (m_left == 0) begin
               if (in_range(m_floor + m_dir)) m_floor = m_floor + m_dir;
               m_phase = PH_CHECK;
            end
         end
         PH_CHECK: begin
            if (req[m_floor]) begin
               m_phase = PH_DOOR; m_left = DOT; m_served = 1'b1; m_presses = 0;
            end else if (m_dir != 0 && md == m_dir && in_range(m_floor + m_dir)) begin
               m_phase = PH_MOVE; m_left = TPF;
            end else begin
               m_phase = PH_IDLE; m_dir = 0;
            end
         end
         default: begin
            m_left--;
            if (m_left == 0) begin
               m_phase = PH_IDLE; m_dir = 0;
            end else if (HOLD_EN && hold && !m_hold_d && m_presses < 4) begin
               m_presses++;
               m_left = (m_left + HT > DOT) ? DOT : m_left + HT;
            end
         end
      endcase
      m_hold_d = hold;
   endtask

   function automatic logic [11:0] model_out();
      logic [3:0] p;
      logic [1:0] d;
      p = 4'b0001 << m_floor;
      d = (m_dir == 1) ? 2'b01 : ((m_dir == -1) ? 2'b10 : 2'b00);
      return pack_out(p, m_phase == PH_DOOR, m_phase == PH_MOVE, d, m_served ? p : 4'b0000);
   endfunction

   // Door cycle at floor 1 with optional hold presses 40 cycles apart from open cycle 50.
   task automatic door_run(input int n_press, input int exp_len, input string tag);
      int len;
      stop_req = 4'b0001;
      tick();
      check({tag, "_open"}, dut_out(), pack_out(4'b0001, 1'b1, 1'b0, 2'b00, 4'b0001));
      stop_req = 4'b0000;
      len = 0;
      for (int i = 0; i < 400 && door_open; i++) begin
         len++;
         door_hold = 1'b0;
         for (int p = 0; p < n_press; p++)
            if (len == 50 + 40 * p) door_hold = 1'b1;
         tick();
      end
      door_hold = 1'b0;
      check({tag, "_len"}, len, exp_len);
      check({tag, "_closed"}, dut_out(), pack_out(4'b0001, 1'b0, 1'b0, 2'b00, 4'b0000));
   endtask

   initial begin
      vecs[0] = '{2'b00, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'b00, 4'b0000};
      vecs[1] = '{2'b01, 4'b0000, 4'b0001, 1'b0, 1'b1, 2'b01, 4'b0000};
      vecs[2] = '{2'b10, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'b00, 4'b0000};
      vecs[3] = '{2'b11, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'b00, 4'b0000};
      vecs[4] = '{2'b01, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'b00, 4'b0001};
      vecs[5] = '{2'b00, 4'b0010, 4'b0001, 1'b0, 1'b0, 2'b00, 4'b0000};
      vecs[6] = '{2'b10, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'b00, 4'b0001};
      vecs[7] = '{2'b01, 4'b1110, 4'b0001, 1'b0, 1'b1, 2'b01, 4'b0000};

      // reset state and idle hold
      do_reset();
      check("reset_state", dut_out(), pack_out(4'b0001, 1'b0, 1'b0, 2'b00, 4'b0000));
      for (int i = 0; i < 200; i++) begin
         tick();
         check("idle_hold", dut_out(), pack_out(4'b0001, 1'b0, 1'b0, 2'b00, 4'b0000));
      end

      // IDLE decision table from floor 1
      for (int i = 0; i < 8; i++) begin
         do_reset();
         ud_mode  = vecs[i].mode;
         stop_req = vecs[i].req;
         tick();
         check($sformatf("idle_vec%0d", i), dut_out(),
               pack_out(vecs[i].e_pos, vecs[i].e_door, vecs[i].e_mov, vecs[i].e_dir, vecs[i].e_served));
      end

      // door timing, with and without hold presses
      do_reset();
      door_run(0, DOT, "door_plain");
      do_reset();
      door_run(1, HOLD_EN ? DOT + HT : DOT, "door_hold1");
      do_reset();
      door_run(5, HOLD_EN ? DOT + 4 * HT : DOT, "door_hold5");

      // up trip with a stop at floor 3; mode flips mid-floor are ignored
      do_reset();
      ud_mode  = 2'b01;
      stop_req = 4'b0100;
      for (int k = 1; k <= 132; k++) begin
         if (k == 30) ud_mode = 2'b10;
         if (k == 50) ud_mode = 2'b01;
         tick();
         case (k)
            1:   check("trip_start",  dut_out(), pack_out(4'b0001, 1'b0, 1'b1, 2'b01, 4'b0000));
            64:  check("trip_f1_end", dut_out(), pack_out(4'b0001, 1'b0, 1'b1, 2'b01, 4'b0000));
            65:  check("trip_f2",     dut_out(), pack_out(4'b0010, 1'b0, 1'b0, 2'b01, 4'b0000));
            66:  check("trip_cont",   dut_out(), pack_out(4'b0010, 1'b0, 1'b1, 2'b01, 4'b0000));
            130: check("trip_f3",     dut_out(), pack_out(4'b0100, 1'b0, 1'b0, 2'b01, 4'b0000));
            131: check("trip_door",   dut_out(), pack_out(4'b0100, 1'b1, 1'b0, 2'b01, 4'b0100));
            132: check("trip_pulse",  dut_out(), pack_out(4'b0100, 1'b1, 1'b0, 2'b01, 4'b0000));
            default: ;
         endcase
      end

      // run to the top floor, end-floor guard, forced shift at floor 4
      do_reset();
      ud_mode = 2'b01;
      for (int k = 1; k <= 196; k++) begin
         tick();
         if (k == 195) check("top_check", dut_out(), pack_out(4'b1000, 1'b0, 1'b0, 2'b01, 4'b0000));
         if (k == 196) check("top_idle",  dut_out(), pack_out(4'b1000, 1'b0, 1'b0, 2'b00, 4'b0000));
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         check("end_guard", dut_out(), pack_out(4'b1000, 1'b0, 1'b0, 2'b00, 4'b0000));
      end
      force dut.r_state = elevator_pkg::MOVE;
      force dut.r_dir   = 2'b01;
      for (int i = 0; i < 70; i++) begin
         tick();
         check("sat_up", position, 4'b1000);
      end
      release dut.r_state;
      release dut.r_dir;

      // asynchronous reset while travelling from floor 2
      do_reset();
      ud_mode = 2'b01;
      for (int k = 0; k < 96; k++) tick();
      check("pre_rst_move", dut_out(), pack_out(4'b0010, 1'b0, 1'b1, 2'b01, 4'b0000));
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", dut_out(), pack_out(4'b0001, 1'b0, 1'b0, 2'b00, 4'b0000));
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("restart", dut_out(), pack_out(4'b0001, 1'b0, 1'b1, 2'b01, 4'b0000));

      // random stimulus against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (m_served) stop_req = stop_req & ~(4'b0001 << m_floor);
         if ($urandom_range(0, 63) == 0) ud_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) stop_req = stop_req | (4'b0001 << $urandom_range(0, 3));
         door_hold = ($urandom_range(0, 19) == 0);
         model_step(ud_mode, stop_req, door_hold);
         tick();
         check($sformatf("rand_%0d", i), dut_out(), model_out());
      end
      door_hold = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
